// File: rtl/mux_viii_rr_arbiter_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter:
// requester count, index width, FSM state encoding and a one-hot helper.
package mux_viii_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // Turn a requester index into its one-hot grant pattern.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_viii_rr_arbiter_rr_pick8.sv
// Circular priority search: returns the first set request bit found when
// scanning from ptr+1 upward, wrapping through 7 -> 0, and ending at ptr itself.
import mux_viii_rr_arbiter_pkg::*;

module rr_pick8 (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // Scan the eight positions after ptr; the 3-bit add gives the mod-8 wrap.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_viii_rr_arbiter.sv
// Round-robin arbiter for an 8:1 single-bit mux. Owns the mux select and a
// one-hot grant, and bounds each ownership to HOLD_MAX cycles while other
// requesters are waiting.
import mux_viii_rr_arbiter_pkg::*;

module mux_viii_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int HOLD_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] select,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] select_q, select_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic             own_req;
  logic [N_REQ-1:0] others;
  logic [N_REQ-1:0] pick_req;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             hold_expired;

  // The single picker serves both states: in OWN it only sees the other
  // requesters so a preemption or handover can never re-pick the owner.
  always_comb begin
    own_req      = req[select_q];
    others       = req & ~idx_to_onehot(select_q);
    pick_req     = (state_q == ST_OWN) ? others : req;
    hold_expired = (cnt_q == HOLD_W'(HOLD_MAX));
  end

  rr_pick8 u_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic: grant on request, hand over on release, preempt when
  // the hold budget is spent, restart the counter if nobody else is waiting.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          state_d  = ST_OWN;
          grant_d  = idx_to_onehot(pick_idx);
          select_d = pick_idx;
          ptr_d    = pick_idx;
          cnt_d    = HOLD_W'(1);
        end
      end
      ST_OWN: begin
        if ((!own_req || hold_expired) && pick_found) begin
          grant_d  = idx_to_onehot(pick_idx);
          select_d = pick_idx;
          ptr_d    = pick_idx;
          cnt_d    = HOLD_W'(1);
        end else if (!own_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (hold_expired) begin
          cnt_d = HOLD_W'(1);
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, pointer, counter and output registers with synchronous reset;
  // the pointer resets to 7 so the first search begins at requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      select_q <= '0;
      ptr_q    <= IDX_W'(N_REQ - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign busy   = |grant_q;

endmodule

// File: tb/tb_mux_viii_rr_arbiter.sv
// Directed and randomized checks for the round-robin mux arbiter.
module tb_mux_viii_rr_arbiter;

  localparam int HOLD_MAX = 4;
  localparam int HOLD_W   = 3;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] select;
  logic       busy;
  logic [7:0] mux_data;
  logic       mux_out;

  int checks;
  int passes;

  // Reference model state for the randomized run.
  int         m_own, m_sel, m_ptr, m_cnt;
  logic       m_busy;
  logic [7:0] m_grant;
  int         wait_cnt [8];

  mux_viii_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .HOLD_W(HOLD_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .select (select),
    .busy   (busy)
  );

  // The shared 8:1 mux that the arbiter steers.
  assign mux_out = mux_data[select];

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive req, let one rising edge pass, then settle before sampling.
  task automatic applyStimulus(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    applyStimulus(8'h00);
    reset = 1'b0;
  endtask

  function automatic int search(input logic [7:0] r, input int from);
    int idx;
    for (int k = 1; k <= 8; k++) begin
      idx = (from + k) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic rst);
    logic [7:0] oth;
    int w;
    if (rst) begin
      m_busy = 1'b0; m_own = 0; m_sel = 0; m_cnt = 0; m_ptr = 7;
    end else if (!m_busy) begin
      w = search(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1; m_own = w; m_sel = w; m_ptr = w; m_cnt = 1;
      end
    end else if (r[m_own] && m_cnt < HOLD_MAX) begin
      m_cnt = m_cnt + 1;
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      w = search(oth, m_own);
      if (w >= 0) begin
        m_own = w; m_sel = w; m_ptr = w; m_cnt = 1;
      end else if (r[m_own]) begin
        m_cnt = 1;
      end else begin
        m_busy = 1'b0; m_cnt = 0;
      end
    end
    m_grant = m_busy ? (8'h01 << m_own) : 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 8'h00) $display("[TB] FAIL reset_grant: got %h expected 00", grant); else passes++;
    checks++; if (select !== 3'd0) $display("[TB] FAIL reset_select: got %0d expected 0", select); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_single();
    do_reset();
    applyStimulus(8'h01);
    checks++; if (grant !== 8'h01) $display("[TB] FAIL single_grant: got %h expected 01", grant); else passes++;
    checks++; if (select !== 3'd0) $display("[TB] FAIL single_select: got %0d expected 0", select); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", busy); else passes++;
    applyStimulus(8'h00);
    checks++; if (grant !== 8'h00) $display("[TB] FAIL drop_grant: got %h expected 00", grant); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL drop_busy: got %b expected 0", busy); else passes++;
    checks++; if (select !== 3'd0) $display("[TB] FAIL drop_select: got %0d expected 0", select); else passes++;
  endtask

  task automatic test_rotate();
    logic [2:0] exp_sel;
    logic [7:0] one;
    one = 8'h01;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      applyStimulus(8'hFF);
      exp_sel = 3'((i / 4) % 8);
      checks++; if (select !== exp_sel) $display("[TB] FAIL rotate_select[%0d]: got %0d expected %0d", i, select, exp_sel); else passes++;
      checks++; if (grant !== (one << exp_sel)) $display("[TB] FAIL rotate_grant[%0d]: got %h expected %h", i, grant, one << exp_sel); else passes++;
    end
    applyStimulus(8'h00);
  endtask

  task automatic test_handover();
    do_reset();
    applyStimulus(8'h05);
    applyStimulus(8'h05);
    checks++; if (select !== 3'd0) $display("[TB] FAIL handover_pre_select: got %0d expected 0", select); else passes++;
    applyStimulus(8'h04);
    checks++; if (grant !== 8'h04) $display("[TB] FAIL handover_grant: got %h expected 04", grant); else passes++;
    checks++; if (select !== 3'd2) $display("[TB] FAIL handover_select: got %0d expected 2", select); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL handover_busy: got %b expected 1", busy); else passes++;
    applyStimulus(8'h00);
  endtask

  task automatic test_hold_single();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(8'h08);
      checks++; if (grant !== 8'h08) $display("[TB] FAIL hold_grant[%0d]: got %h expected 08", i, grant); else passes++;
      checks++; if (dut.cnt_q !== 3'((i % 4) + 1)) $display("[TB] FAIL hold_cnt[%0d]: got %0d expected %0d", i, dut.cnt_q, (i % 4) + 1); else passes++;
    end
    applyStimulus(8'h0A);
    checks++; if (select !== 3'd1) $display("[TB] FAIL hold_preempt_select: got %0d expected 1", select); else passes++;
    checks++; if (grant !== 8'h02) $display("[TB] FAIL hold_preempt_grant: got %h expected 02", grant); else passes++;
    applyStimulus(8'h00);
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 22; i++) applyStimulus(8'hFF);
    checks++; if (select !== 3'd5) $display("[TB] FAIL midrst_pre_select: got %0d expected 5", select); else passes++;
    checks++; if (dut.cnt_q !== 3'd2) $display("[TB] FAIL midrst_pre_cnt: got %0d expected 2", dut.cnt_q); else passes++;
    reset = 1'b1;
    applyStimulus(8'hFF);
    checks++; if (grant !== 8'h00) $display("[TB] FAIL midrst_grant: got %h expected 00", grant); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passes++;
    checks++; if (select !== 3'd0) $display("[TB] FAIL midrst_select: got %0d expected 0", select); else passes++;
    reset = 1'b0;
    applyStimulus(8'hFF);
    checks++; if (grant !== 8'h01) $display("[TB] FAIL midrst_first_grant: got %h expected 01", grant); else passes++;
    applyStimulus(8'h00);
  endtask

  task automatic test_random();
    logic [7:0] r;
    do_reset();
    model_step(8'h00, 1'b1);
    for (int b = 0; b < 8; b++) wait_cnt[b] = 0;
    r = 8'h00;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      mux_data = 8'($urandom);
      applyStimulus(r);
      model_step(r, 1'b0);
      checks++; if (grant !== m_grant) $display("[TB] FAIL rand_grant@%0d: got %h expected %h", cyc, grant, m_grant); else passes++;
      checks++; if (select !== 3'(m_sel)) $display("[TB] FAIL rand_select@%0d: got %0d expected %0d", cyc, select, m_sel); else passes++;
      checks++; if (busy !== m_busy) $display("[TB] FAIL rand_busy@%0d: got %b expected %b", cyc, busy, m_busy); else passes++;
      checks++; if (!$onehot0(grant)) $display("[TB] FAIL inv_onehot@%0d: got %h expected one-hot or zero", cyc, grant); else passes++;
      checks++; if (busy !== (|grant)) $display("[TB] FAIL inv_busy@%0d: got %b expected %b", cyc, busy, |grant); else passes++;
      if (m_busy) begin
        checks++; if (grant[select] !== 1'b1) $display("[TB] FAIL inv_grant_select@%0d: got grant %h select %0d", cyc, grant, select); else passes++;
        checks++; if (mux_out !== mux_data[m_own]) $display("[TB] FAIL rand_mux@%0d: got %b expected %b", cyc, mux_out, mux_data[m_own]); else passes++;
        checks++; if (dut.cnt_q < 3'd1 || dut.cnt_q > 3'(HOLD_MAX)) $display("[TB] FAIL inv_cnt@%0d: got %0d expected 1..%0d", cyc, dut.cnt_q, HOLD_MAX); else passes++;
      end
      for (int b = 0; b < 8; b++) begin
        if (r[b] && !grant[b]) wait_cnt[b]++;
        else wait_cnt[b] = 0;
        if (wait_cnt[b] > 7 * HOLD_MAX) begin
          checks++;
          $display("[TB] FAIL wait_bound@%0d req%0d: got %0d expected <= %0d", cyc, b, wait_cnt[b], 7 * HOLD_MAX);
          wait_cnt[b] = 0;
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    reset    = 1'b1;
    req      = 8'h00;
    mux_data = 8'hA5;
    test_reset();
    test_single();
    test_rotate();
    test_handover();
    test_hold_single();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
